// File: rtl/cm_sketch_cam_top.sv
// Heavy-hitter tracker: an H3-hashed count-min sketch estimates per-address counts
// and feeds a CAM kept sorted by descending count; entry 0 is the hottest address.

module compute_hash #(
   parameter int unsigned ADDR_SIZE = 28,
   parameter int unsigned NUM_HASH  = 4,
   parameter int unsigned HASH_SIZE = 4
) (
   input  logic [ADDR_SIZE-1:0]               addr,
   output logic [NUM_HASH-1:0][HASH_SIZE-1:0] hash_c
);
   logic [HASH_SIZE-1:0] q_debug [NUM_HASH][32];
   logic [31:0]          addr_ext;

   // Fixed H3 seed matrix derived from golden-ratio style constants
   for (genvar i = 0; i < NUM_HASH; i++) begin : g_row
      for (genvar j = 0; j < 32; j++) begin : g_bit
         localparam logic [31:0] SEED = 32'(j) * 32'h9E3779B1 + 32'(i) * 32'h85EBCA77 + 32'd1;
         assign q_debug[i][j] = SEED[HASH_SIZE+15:16];
      end
   end

   assign addr_ext = 32'(addr);

   always_comb begin
      hash_c = '0;
      for (int i = 0; i < NUM_HASH; i++) begin
         for (int j = 0; j < 32; j++) begin
            if (addr_ext[j]) hash_c[i] = hash_c[i] ^ q_debug[i][j];
         end
      end
   end
endmodule

module cm_sketch #(
   parameter int unsigned ADDR_SIZE = 28,
   parameter int unsigned CNT_SIZE  = 32,
   parameter int unsigned W         = 16,
   parameter int unsigned NUM_HASH  = 4,
   parameter int unsigned HASH_SIZE = $clog2(W)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 input_valid,
   input  logic [ADDR_SIZE-1:0] input_addr,
   output logic                 est_valid,
   output logic [ADDR_SIZE-1:0] est_addr,
   output logic [CNT_SIZE-1:0]  est_cnt
);
   logic [NUM_HASH-1:0][HASH_SIZE-1:0] hash_c;
   logic [NUM_HASH-1:0][HASH_SIZE-1:0] hash_s1;
   logic                               s1_valid;
   logic [ADDR_SIZE-1:0]               s1_addr;
   logic [CNT_SIZE-1:0]                counters [NUM_HASH][W];
   logic [CNT_SIZE-1:0]                inc_c    [NUM_HASH];
   logic [CNT_SIZE-1:0]                min_c;

   compute_hash #(
      .ADDR_SIZE (ADDR_SIZE),
      .NUM_HASH  (NUM_HASH),
      .HASH_SIZE (HASH_SIZE)
   ) compute_hash (
      .addr   (input_addr),
      .hash_c (hash_c)
   );

   // Stage 1: capture address and row indices
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_addr  <= '0;
         hash_s1  <= '0;
      end else begin
         s1_valid <= input_valid;
         if (input_valid) begin
            s1_addr <= input_addr;
            hash_s1 <= hash_c;
         end
      end
   end

   // Saturating increment per row; the estimate is the smallest incremented value
   always_comb begin
      min_c = '1;
      for (int i = 0; i < NUM_HASH; i++) begin
         inc_c[i] = counters[i][hash_s1[i]];
         if (inc_c[i] != '1) inc_c[i] = inc_c[i] + CNT_SIZE'(1);
         if (inc_c[i] < min_c) min_c = inc_c[i];
      end
   end

   // Stage 2: read-increment-write in one edge so back-to-back hits never lose counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_HASH; i++) begin
            for (int k = 0; k < W; k++) counters[i][k] <= '0;
         end
         est_valid <= 1'b0;
         est_addr  <= '0;
         est_cnt   <= '0;
      end else begin
         est_valid <= s1_valid;
         if (s1_valid) begin
            for (int i = 0; i < NUM_HASH; i++) counters[i][hash_s1[i]] <= inc_c[i];
            est_addr <= s1_addr;
            est_cnt  <= min_c;
         end
      end
   end
endmodule

module cam #(
   parameter int unsigned ADDR_SIZE  = 28,
   parameter int unsigned CNT_SIZE   = 32,
   parameter int unsigned NUM_ENTRY  = 25,
   parameter int unsigned INDEX_SIZE = $clog2(NUM_ENTRY)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 input_valid,
   input  logic [ADDR_SIZE-1:0] in_addr,
   input  logic [CNT_SIZE-1:0]  in_cnt,
   output logic [ADDR_SIZE-1:0] head_addr,
   output logic [CNT_SIZE-1:0]  head_cnt
);
   localparam int unsigned LAST = NUM_ENTRY - 1;

   logic [CNT_SIZE-1:0]   cnt_array   [NUM_ENTRY];
   logic [ADDR_SIZE-1:0]  addr_array  [NUM_ENTRY];
   logic [CNT_SIZE-1:0]   cnt_cmp_c   [NUM_ENTRY];
   logic [ADDR_SIZE-1:0]  addr_cmp_c  [NUM_ENTRY];
   logic [CNT_SIZE-1:0]   cnt_nxt_c   [NUM_ENTRY];
   logic [ADDR_SIZE-1:0]  addr_nxt_c  [NUM_ENTRY];
   logic                  hit_c;
   logic                  upd_c;
   logic [INDEX_SIZE-1:0] hit_idx_c;
   int unsigned           rm_c;
   int unsigned           pos_c;

   // Remove the hit entry (or the tail on a miss), then reinsert below all entries >= new count
   always_comb begin
      hit_c     = 1'b0;
      hit_idx_c = '0;
      for (int k = int'(LAST); k >= 0; k--) begin
         if (cnt_array[k] != '0 && addr_array[k] == in_addr) begin
            hit_c     = 1'b1;
            hit_idx_c = INDEX_SIZE'(k);
         end
      end
      upd_c = input_valid && (hit_c || in_cnt > cnt_array[LAST]);
      rm_c  = hit_c ? 32'(hit_idx_c) : LAST;

      for (int unsigned k = 0; k < LAST; k++) begin
         if (k < rm_c) begin
            cnt_cmp_c[k]  = cnt_array[k];
            addr_cmp_c[k] = addr_array[k];
         end else begin
            cnt_cmp_c[k]  = cnt_array[k+1];
            addr_cmp_c[k] = addr_array[k+1];
         end
      end
      cnt_cmp_c[LAST]  = '0;
      addr_cmp_c[LAST] = '0;

      pos_c = 0;
      for (int unsigned k = 0; k < LAST; k++) begin
         if (cnt_cmp_c[k] >= in_cnt) pos_c = pos_c + 1;
      end

      cnt_nxt_c[0]  = (pos_c == 0) ? in_cnt  : cnt_cmp_c[0];
      addr_nxt_c[0] = (pos_c == 0) ? in_addr : addr_cmp_c[0];
      for (int unsigned k = 1; k < NUM_ENTRY; k++) begin
         if (k < pos_c) begin
            cnt_nxt_c[k]  = cnt_cmp_c[k];
            addr_nxt_c[k] = addr_cmp_c[k];
         end else if (k == pos_c) begin
            cnt_nxt_c[k]  = in_cnt;
            addr_nxt_c[k] = in_addr;
         end else begin
            cnt_nxt_c[k]  = cnt_cmp_c[k-1];
            addr_nxt_c[k] = addr_cmp_c[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NUM_ENTRY; k++) begin
            cnt_array[k]  <= '0;
            addr_array[k] <= '0;
         end
      end else if (upd_c) begin
         for (int k = 0; k < NUM_ENTRY; k++) begin
            cnt_array[k]  <= cnt_nxt_c[k];
            addr_array[k] <= addr_nxt_c[k];
         end
      end
   end

   assign head_addr = addr_array[0];
   assign head_cnt  = cnt_array[0];
endmodule

module cm_sketch_cam_top #(
   parameter int unsigned ADDR_SIZE  = 28,
   parameter int unsigned CNT_SIZE   = 32,
   parameter int unsigned W          = 16,
   parameter int unsigned NUM_HASH   = 4,
   parameter int unsigned HASH_SIZE  = $clog2(W),
   parameter int unsigned NUM_ENTRY  = 25,
   parameter int unsigned INDEX_SIZE = $clog2(NUM_ENTRY)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 input_valid,
   input  logic [ADDR_SIZE-1:0] input_addr,
   output logic [ADDR_SIZE-1:0] top_addr,
   output logic [CNT_SIZE-1:0]  top_cnt
);
   logic                 est_valid;
   logic [ADDR_SIZE-1:0] est_addr;
   logic [CNT_SIZE-1:0]  est_cnt;
   logic [ADDR_SIZE-1:0] head_addr;
   logic [CNT_SIZE-1:0]  head_cnt;

   cm_sketch #(
      .ADDR_SIZE (ADDR_SIZE),
      .CNT_SIZE  (CNT_SIZE),
      .W         (W),
      .NUM_HASH  (NUM_HASH),
      .HASH_SIZE (HASH_SIZE)
   ) cm_sketch_0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_valid (input_valid),
      .input_addr  (input_addr),
      .est_valid   (est_valid),
      .est_addr    (est_addr),
      .est_cnt     (est_cnt)
   );

   cam #(
      .ADDR_SIZE  (ADDR_SIZE),
      .CNT_SIZE   (CNT_SIZE),
      .NUM_ENTRY  (NUM_ENTRY),
      .INDEX_SIZE (INDEX_SIZE)
   ) cam_0 (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_valid (est_valid),
      .in_addr     (est_addr),
      .in_cnt      (est_cnt),
      .head_addr   (head_addr),
      .head_cnt    (head_cnt)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_addr <= '0;
         top_cnt  <= '0;
      end else begin
         top_addr <= head_addr;
         top_cnt  <= head_cnt;
      end
   end
endmodule

// File: tb/tb_cm_sketch_cam_top.sv
// Scoreboard bench for cm_sketch_cam_top: a queue-based heavy-hitter model predicts
// top_addr/top_cnt four negedges after each driven cycle and the final table contents.

module tb_cm_sketch_cam_top;
   localparam int unsigned ADDR_SIZE = 28;
   localparam int unsigned CNT_SIZE  = 32;
   localparam int unsigned W         = 16;
   localparam int unsigned NUM_HASH  = 4;
   localparam int unsigned HASH_SIZE = 4;
   localparam int unsigned NUM_ENTRY = 25;
   localparam longint unsigned MAXC  = (64'd1 << CNT_SIZE) - 64'd1;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 input_valid = 1'b0;
   logic [ADDR_SIZE-1:0] input_addr = '0;
   logic [ADDR_SIZE-1:0] top_addr;
   logic [CNT_SIZE-1:0]  top_cnt;

   always #5 clk = ~clk;

   cm_sketch_cam_top dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .input_valid (input_valid),
      .input_addr  (input_addr),
      .top_addr    (top_addr),
      .top_cnt     (top_cnt)
   );

   typedef struct {
      int unsigned          due;
      logic [ADDR_SIZE-1:0] addr;
      logic [CNT_SIZE-1:0]  cnt;
   } exp_t;

   typedef struct {
      logic [ADDR_SIZE-1:0] addr;
      logic [CNT_SIZE-1:0]  cnt;
   } ent_t;

   exp_t            sb[$];
   ent_t            tbl[$];
   longint unsigned sk [NUM_HASH][W];
   int unsigned     cyc = 0;
   int              checks = 0;
   int              errors = 0;
   logic [ADDR_SIZE-1:0] pool [40];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [HASH_SIZE-1:0] seed(input int i, input int j);
      logic [31:0] t;
      t = 32'(j) * 32'h9E3779B1 + 32'(i) * 32'h85EBCA77 + 32'd1;
      return t[HASH_SIZE+15:16];
   endfunction

   function automatic logic [HASH_SIZE-1:0] hash_of(input int i, input logic [ADDR_SIZE-1:0] a);
      logic [HASH_SIZE-1:0] h;
      h = '0;
      for (int j = 0; j < int'(ADDR_SIZE); j++) if (a[j]) h = h ^ seed(i, j);
      return h;
   endfunction

   task automatic model_clear();
      tbl.delete();
      for (int i = 0; i < NUM_HASH; i++)
         for (int k = 0; k < W; k++) sk[i][k] = 0;
   endtask

   // Sketch estimate, then a top-N list of (addr,count) kept sorted, newcomers below ties
   task automatic model_access(input logic [ADDR_SIZE-1:0] a);
      longint unsigned est;
      int              idx;
      int              pos;
      logic [HASH_SIZE-1:0] h;
      ent_t            e;
      est = MAXC;
      for (int i = 0; i < NUM_HASH; i++) begin
         h = hash_of(i, a);
         if (sk[i][h] < MAXC) sk[i][h] = sk[i][h] + 1;
         if (sk[i][h] < est) est = sk[i][h];
      end
      idx = -1;
      for (int k = 0; k < tbl.size(); k++) if (tbl[k].addr == a) idx = k;
      if (idx >= 0) tbl.delete(idx);
      else if (tbl.size() == NUM_ENTRY) begin
         if (est > 64'(tbl[NUM_ENTRY-1].cnt)) tbl.delete(NUM_ENTRY-1);
         else return;
      end
      pos = 0;
      while (pos < tbl.size() && 64'(tbl[pos].cnt) >= est) pos++;
      e.addr = a;
      e.cnt  = CNT_SIZE'(est);
      tbl.insert(pos, e);
   endtask

   task automatic drive(input logic v, input logic [ADDR_SIZE-1:0] a);
      exp_t x;
      @(negedge clk);
      input_valid = v;
      input_addr  = a;
      if (v) model_access(a);
      x.due  = cyc + 4;
      x.addr = (tbl.size() > 0) ? tbl[0].addr : '0;
      x.cnt  = (tbl.size() > 0) ? tbl[0].cnt  : '0;
      sb.push_back(x);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) drive(1'b0, '0);
   endtask

   task automatic check_table(input string tag);
      logic [ADDR_SIZE-1:0] ea;
      logic [CNT_SIZE-1:0]  ec;
      for (int k = 0; k < NUM_ENTRY; k++) begin
         ea = (k < tbl.size()) ? tbl[k].addr : '0;
         ec = (k < tbl.size()) ? tbl[k].cnt  : '0;
         check($sformatf("%s_cnt[%0d]", tag, k), 64'(dut.cam_0.cnt_array[k]), 64'(ec));
         check($sformatf("%s_addr[%0d]", tag, k), 64'(dut.cam_0.addr_array[k]), 64'(ea));
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      input_valid = 1'b0;
      rst_n = 1'b0;
      sb.delete();
      model_clear();
      #1;
      check("rst_top_addr", 64'(top_addr), 64'd0);
      check("rst_top_cnt", 64'(top_cnt), 64'd0);
      check("rst_cam_valid", 64'(dut.cam_0.input_valid), 64'd0);
      check_table("rst");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: compare each due expectation against the registered top outputs
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         check("top_addr", 64'(top_addr), 64'(e.addr));
         check("top_cnt", 64'(top_cnt), 64'(e.cnt));
      end
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   initial begin
      model_clear();
      do_reset();

      // Seed matrix dump
      for (int i = 0; i < NUM_HASH; i++)
         for (int j = 0; j < 32; j++)
            check($sformatf("q_debug[%0d][%0d]", i, j),
                  64'(dut.cm_sketch_0.compute_hash.q_debug[i][j]), 64'(seed(i, j)));

      // Single access
      drive(1'b1, 28'h0000005);
      idle(5);
      check("single_cnt0", 64'(dut.cam_0.cnt_array[0]), 64'd1);
      check("single_addr0", 64'(dut.cam_0.addr_array[0]), 64'h5);
      check_table("single");

      // A x3 then B, back-to-back
      do_reset();
      for (int k = 0; k < 3; k++) drive(1'b1, 28'h10);
      drive(1'b1, 28'h20);
      idle(5);
      check("ab_cnt0", 64'(dut.cam_0.cnt_array[0]), 64'd3);
      check("ab_addr0", 64'(dut.cam_0.addr_array[0]), 64'h10);
      check("ab_cnt1", 64'(dut.cam_0.cnt_array[1]), 64'd1);
      check("ab_addr1", 64'(dut.cam_0.addr_array[1]), 64'h20);
      check_table("ab");

      // B, A, B, B: tie keeps earlier entry above
      do_reset();
      drive(1'b1, 28'h20);
      drive(1'b1, 28'h10);
      drive(1'b1, 28'h20);
      drive(1'b1, 28'h20);
      idle(5);
      check("ba_cnt0", 64'(dut.cam_0.cnt_array[0]), 64'd3);
      check("ba_addr0", 64'(dut.cam_0.addr_array[0]), 64'h20);
      check("ba_cnt1", 64'(dut.cam_0.cnt_array[1]), 64'd1);
      check("ba_addr1", 64'(dut.cam_0.addr_array[1]), 64'h10);
      check_table("ba");

      // 26 distinct addresses: table fill and tail replacement rule
      do_reset();
      for (int k = 0; k < 26; k++) drive(1'b1, ADDR_SIZE'(32'h100 + 32'(k) * 32'h3));
      idle(5);
      check_table("fill");

      // Reset one cycle after an access discards it
      do_reset();
      drive(1'b1, 28'h77);
      do_reset();
      idle(6);
      check_table("midrst");

      // Randomized hot/cold traffic over a small address pool
      do_reset();
      for (int k = 0; k < 40; k++) pool[k] = ADDR_SIZE'($urandom());
      for (int k = 0; k < 400; k++) begin
         if ($urandom_range(3) != 0) drive(1'b1, pool[$urandom_range(k % 2 == 0 ? 9 : 39)]);
         else drive(1'b0, '0);
      end
      idle(5);
      check_table("rand");

      @(negedge clk);
      input_valid = 1'b0;
      for (int k = 0; k < 8 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
